pulse_burst_controller: RTL



---
 rtl/pulse_burst_controller_pkg.sv | 11 +
 rtl/adder_n.sv | 22 ++
 rtl/comparator_eq.sv | 13 +
 rtl/pulse_generator.sv | 41 ++++
 rtl/register.sv | 33 +++
 rtl/pulse_burst_controller.sv | 136 +++++++++++++
 6 files changed

// File: rtl/pulse_burst_controller_pkg.sv
// Shared types for the pulse burst controller.
// Holds the burst sequencer state encoding.
package pulse_burst_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } burst_state_t;

endpackage

// File: rtl/adder_n.sv
// Ripple-carry adder, W bits, carry out discarded.
// Built from gates so no arithmetic operator is inferred.
module adder_n #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W-1:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        if (i < W - 1) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/comparator_eq.sv
// Equality comparator, W bits.
// XOR every bit pair, then NOR-reduce.
module comparator_eq #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq
);

    assign eq = ~|(a ^ b);

endmodule

// File: rtl/pulse_generator.sv
// Periodic pulse source: pulse when count+1 matches ticks.
// The caller clears the counter through rst, usually on each pulse.
module pulse_generator #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] ticks,
    output logic         pulse
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] cnt;
    logic [N-1:0] cnt_inc;
    logic         hit;

    adder_n #(.W(N)) u_inc (
        .a   (cnt),
        .b   (ONE),
        .sum (cnt_inc)
    );

    comparator_eq #(.W(N)) u_hit (
        .a  (cnt_inc),
        .b  (ticks),
        .eq (hit)
    );

    register #(.W(N)) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (ena),
        .d   (cnt_inc),
        .q   (cnt)
    );

    assign pulse = ena & hit;

endmodule

// File: rtl/register.sv
// W-bit register with load enable.
// Synchronous active-high clear wins over the enable.
module register #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pulse_burst_controller.sv
// Runs one pulse_generator for a latched number of pulses,
// then strobes done for a single cycle.
module pulse_burst_controller
    import pulse_burst_controller_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] ticks,
    input  logic [M-1:0] count,
    output logic         busy,
    output logic         pulse,
    output logic         done
);

    localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

    burst_state_t state_q;
    burst_state_t state_d;

    logic         st_idle;
    logic         st_run;
    logic         st_done;
    logic         accept;
    logic         gen_rst;
    logic         gen_pulse;
    logic         last;
    logic         cnt_en;
    logic [N-1:0] ticks_lat;
    logic [M-1:0] count_lat;
    logic [M-1:0] pcnt;
    logic [M-1:0] pcnt_inc;
    logic [M-1:0] pcnt_d;

    always_comb begin
        st_idle = 1'b0;
        st_run  = 1'b0;
        st_done = 1'b0;
        unique case (state_q)
            S_IDLE:  st_idle = 1'b1;
            S_RUN:   st_run  = 1'b1;
            S_DONE:  st_done = 1'b1;
            default: st_idle = 1'b1;
        endcase
    end

    // Zero period or zero count skips straight to DONE.
    assign accept = st_idle & start & ~(~|ticks) & ~(~|count);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = accept ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gen_pulse && last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    register #(.W(N)) u_ticks (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .d   (ticks),
        .q   (ticks_lat)
    );

    register #(.W(M)) u_count (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .d   (count),
        .q   (count_lat)
    );

    assign gen_rst = rst | accept | gen_pulse;

    pulse_generator #(.N(N)) u_gen (
        .clk   (clk),
        .rst   (gen_rst),
        .ena   (st_run),
        .ticks (ticks_lat),
        .pulse (gen_pulse)
    );

    adder_n #(.W(M)) u_pinc (
        .a   (pcnt),
        .b   (ONE),
        .sum (pcnt_inc)
    );

    comparator_eq #(.W(M)) u_last (
        .a  (pcnt_inc),
        .b  (count_lat),
        .eq (last)
    );

    // A pulse in the abort cycle is shown but not counted.
    assign cnt_en = accept | (st_run & gen_pulse & ~abort);
    assign pcnt_d = accept ? '0 : pcnt_inc;

    register #(.W(M)) u_pcnt (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .d   (pcnt_d),
        .q   (pcnt)
    );

    assign busy  = st_run;
    assign pulse = st_run & gen_pulse;
    assign done  = st_done;

endmodule
